io_port_responder: RTL and testbench
====================================

Name: io_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus.
- Decodes loads/stores aimed at a 32-byte I/O window and drives the processor's PortOut from a writable register.
- Synchronises PortIn and captures value changes into a small FIFO that software drains with loads.
- The top level selects ReadData from this block instead of DataMemory whenever Hit is high.

Parameters:
BASE_ADDR, 32'hFFFF0000, byte base of the I/O window; bits [4:0] must be 0.
FIFO_DEPTH, 4, capture FIFO entries; power of two, 2..16.
PORT_WIDTH, 8, PortIn width; 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
Address  input  32  byte address (ALU result)
WriteData  input  32  store data (rt register value)
MemWrite  input  1  store strobe for the current cycle
MemRead  input  1  load strobe for the current cycle
PortIn  input  PORT_WIDTH  asynchronous external input pins
Hit  output  1  Address falls in the window; combinational
ReadData  output  32  load data; combinational, 0 when no read hit
PortOut  output  32  registered output port

Behaviour:
- Hit = (Address[31:5] == BASE_ADDR[31:5]).
- Register selected by Address[4:2]. Address[1:0] is ignored (word access only).
- Register map by offset:
  - 0x00 PORT_OUT: RW. Store loads all 32 bits. PortOut = this register.
  - 0x04 PORT_IN: RO. Synchronised PortIn, zero-extended.
  - 0x08 FIFO_DATA: RO. Oldest FIFO entry, zero-extended; 0 when empty.
  - 0x0C STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[8:4] count, other bits 0. Store with WriteData[2]=1 clears overflow (W1C); other bits ignored.
  - 0x10 CTRL: RW. bit0 cap_en; other bits read 0.
  - 0x14-0x1C: Hit=1, read 0, stores ignored.
- Store takes effect at the clock edge of the cycle with MemWrite&Hit. A load in the same cycle sees the old value.
- ReadData is driven only when MemRead&Hit; otherwise ReadData=0.
- PortIn path:
  - Two-flop synchroniser sync1→sync2. PORT_IN reflects a pin change after 2 edges.
  - prev register follows sync2 every cycle.
  - push = cap_en & (sync2 != prev). The captured value is sync2, readable after the 3rd edge following the pin change.
- FIFO pop = MemRead & Hit & offset 0x08 & !empty; pop happens at the clock edge.
  - ReadData in the popping cycle is the pre-pop head.
  - Pop when empty: no state change, ReadData=0.
- Simultaneous push and pop: both happen and count is unchanged, including when full (no overflow).
- Push when full without a pop: sample dropped, overflow set to 1.
- Overflow set and W1C clear in the same cycle: set wins.
- Read and write pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- cap_en cleared: no new pushes; FIFO contents are retained and still poppable.
- MemRead and MemWrite both high: perform both. Read returns the pre-write value.
- Reset values (asynchronous, mid-operation included):
  - PORT_OUT=0, PortOut=0, cap_en=0, overflow=0.
  - FIFO pointers=0, count=0, FIFO storage=0.
  - sync1=sync2=prev=0.
  - ReadData and Hit remain combinational functions of the inputs.
- No stalls or handshake beyond the strobes; every access completes in one cycle.

Test Plan:
- Reset, then store 0xA5A5_0001 to 0xFFFF0000 → PortOut=0xA5A50001 after that edge. Load 0xFFFF0000 returns 0xA5A50001, Hit=1. Address 0x10010000 gives Hit=0, ReadData=0.
- cap_en=1, PortIn 0x00→0x3C → PORT_IN=0x3C after 2 edges. STATUS count=1, empty=0 after 3 edges. Load 0x08 returns 0x3C, then STATUS empty=1.
- Five distinct PortIn changes with depth 4 and no pops → count=4, full=1, overflow=1. Pops return the first four values in order. Store 0x4 to STATUS → overflow=0.
- FIFO full, pop and a new change in the same cycle → count stays 4, overflow stays 0, new value is the last entry.
- Load 0x08 when empty → ReadData=0, count stays 0. cap_en=0 with PortIn toggling → no pushes.
- Assert reset mid-sequence with PortOut=0xFF and count=3 → immediately PortOut=0, count=0, empty=1, cap_en=0, with no clock edge needed.

Source files
------------

// File: rtl/io_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder_if
// Description : Data-memory bus bundle seen by the I/O responder. The
//               processor side is the master, the responder is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Hit;
  logic [31:0] ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead,
    input  Hit, ReadData
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead,
    output Hit, ReadData
  );
endinterface
`default_nettype wire

// File: rtl/io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_port_responder
// Description : Memory-mapped I/O responder for a 32-byte window. Holds the
//               PortOut register, synchronises PortIn and records value
//               changes of the synchronised input into a small FIFO that
//               software drains with loads of FIFO_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          PORT_WIDTH = 8
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  io_port_responder_if.slave         bus,
  input  wire logic [PORT_WIDTH-1:0] PortIn,
  output logic      [31:0]           PortOut
);

  // FIFO_DEPTH is a power of two, so pointers of PTR_W bits wrap naturally.
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] c_off_port_out  = 3'd0;
  localparam logic [2:0] c_off_port_in   = 3'd1;
  localparam logic [2:0] c_off_fifo_data = 3'd2;
  localparam logic [2:0] c_off_status    = 3'd3;
  localparam logic [2:0] c_off_ctrl      = 3'd4;

  // Registered state
  logic [31:0]           r_port_out;
  logic                  r_cap_en;
  logic                  r_ovf;
  logic [PORT_WIDTH-1:0] r_sync1;
  logic [PORT_WIDTH-1:0] r_sync2;
  logic [PORT_WIDTH-1:0] r_prev;
  logic [PORT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  // Combinational decode
  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_rd;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_ovf_set;
  logic        w_ovf_clr;
  logic [4:0]  w_count_ext;
  logic [31:0] w_port_in_ext;
  logic [31:0] w_head_ext;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Byte lane bits are irrelevant for word-only access.
  assign w_unused = &{1'b0, bus.Address[1:0]};

  assign w_hit   = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign w_off   = bus.Address[4:2];
  assign w_wr    = bus.MemWrite & w_hit;
  assign w_rd    = bus.MemRead & w_hit;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));

  // A pop frees the head slot this edge, so a push into a full FIFO is
  // accepted when it coincides with a pop; otherwise it is dropped.
  assign w_pop      = w_rd & (w_off == c_off_fifo_data) & ~w_empty;
  assign w_push_req = r_cap_en & (r_sync2 != r_prev);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_wr & (w_off == c_off_status) & bus.WriteData[2];

  assign w_count_ext = 5'(r_count);
  assign w_status    = {23'd0, w_count_ext, 1'b0, r_ovf, w_full, w_empty};

  assign PortOut = r_port_out;
  assign bus.Hit = w_hit;
  assign bus.ReadData = w_rdata;

  // Zero-extend the synchronised input and the FIFO head to bus width.
  always_comb begin
    w_port_in_ext = '0;
    w_head_ext    = '0;
    w_port_in_ext[PORT_WIDTH-1:0] = r_sync2;
    if (!w_empty) begin
      w_head_ext[PORT_WIDTH-1:0] = r_mem[r_rd_ptr];
    end
  end

  // Load data mux; always reflects pre-edge state so same-cycle stores are not visible.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_off)
        c_off_port_out:  w_rdata = r_port_out;
        c_off_port_in:   w_rdata = w_port_in_ext;
        c_off_fifo_data: w_rdata = w_head_ext;
        c_off_status:    w_rdata = w_status;
        c_off_ctrl:      w_rdata = {31'd0, r_cap_en};
        default:         w_rdata = '0;
      endcase
    end
  end

  // Two-flop synchroniser plus the previous-value register used for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Software-visible control registers; overflow set takes priority over its W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_out <= '0;
      r_cap_en   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr && (w_off == c_off_port_out)) begin
        r_port_out <= bus.WriteData;
      end
      if (w_wr && (w_off == c_off_ctrl)) begin
        r_cap_en <= bus.WriteData[0];
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Capture FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_sync2;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_responder
// Description : Self-checking bench for io_port_responder: directed scenarios
//               with literal expectations, then randomized bus/pin traffic
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_responder;
  localparam logic [31:0] BASE  = 32'hFFFF0000;
  localparam int          DEPTH = 4;
  localparam int          PW    = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pin   = '0;
  logic [31:0]   pout;

  io_port_responder_if bus_if();

  io_port_responder #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .PORT_WIDTH(PW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if.slave),
    .PortIn (pin),
    .PortOut(pout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin samples taken at the last three edges: [0] newest.
  logic [PW-1:0] m_h [3] = '{default: '0};
  logic [PW-1:0] q[$];
  logic [31:0]   m_out = '0;
  logic          m_cap = 1'b0;
  logic          m_ovf = 1'b0;
  logic          mh, mpop, mpreq, mfull, mset, mclr;
  logic [2:0]    mo;

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(q.size());
    return {23'd0, c, 1'b0, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  function automatic logic exp_hit();
    return bus_if.Address[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = '0;
    if (bus_if.MemRead && exp_hit()) begin
      case (bus_if.Address[4:2])
        3'd0: r = m_out;
        3'd1: r = 32'(m_h[1]);
        3'd2: if (q.size() > 0) r = 32'(q[0]);
        3'd3: r = m_status();
        3'd4: r = {31'd0, m_cap};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = '0; m_cap = 1'b0; m_ovf = 1'b0;
      m_h[0] = '0; m_h[1] = '0; m_h[2] = '0;
      q.delete();
    end else begin
      mh    = exp_hit();
      mo    = bus_if.Address[4:2];
      mpop  = bus_if.MemRead && mh && (mo == 3'd2) && (q.size() > 0);
      mpreq = m_cap && (m_h[1] != m_h[2]);
      mfull = (q.size() == DEPTH);
      mset  = mpreq && mfull && !mpop;
      mclr  = bus_if.MemWrite && mh && (mo == 3'd3) && bus_if.WriteData[2];
      if (mpop) void'(q.pop_front());
      if (mpreq && !mset) q.push_back(m_h[1]);
      if (mset) m_ovf = 1'b1;
      else if (mclr) m_ovf = 1'b0;
      if (bus_if.MemWrite && mh && mo == 3'd0) m_out = bus_if.WriteData;
      if (bus_if.MemWrite && mh && mo == 3'd4) m_cap = bus_if.WriteData[0];
      m_h[2] = m_h[1];
      m_h[1] = m_h[0];
      m_h[0] = pin;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("hit", {31'd0, bus_if.Hit}, {31'd0, exp_hit()});
    check("rdata", bus_if.ReadData, exp_rd());
    check("portout", pout, m_out);
  end

  // ---------------- stimulus helpers ----------------
  task automatic setbus(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re);
    bus_if.Address   = a;
    bus_if.WriteData = wd;
    bus_if.MemWrite  = we;
    bus_if.MemRead   = re;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    setbus(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    setbus(BASE | 32'(off), d, 1'b1, 1'b0);
    tick();
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] off, input logic [31:0] exp);
    setbus(BASE | 32'(off), 32'd0, 1'b0, 1'b1);
    #2;
    check(nm, bus_if.ReadData, exp);
    tick();
  endtask

  initial begin
    logic [PW-1:0] v;
    setbus(32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_portout", pout, 32'd0);
    rd_chk("rst_status", 5'h0C, 32'h0000_0001);
    rd_chk("rst_ctrl", 5'h10, 32'd0);

    // PORT_OUT store/load and window decode
    wr(5'h00, 32'hA5A5_0001);
    check("portout_store", pout, 32'hA5A5_0001);
    setbus(BASE, 32'd0, 1'b0, 1'b1);
    #2;
    check("hit_in_window", {31'd0, bus_if.Hit}, 32'd1);
    check("rd_portout", bus_if.ReadData, 32'hA5A5_0001);
    tick();
    setbus(32'h1001_0000, 32'd0, 1'b0, 1'b1);
    #2;
    check("hit_outside", {31'd0, bus_if.Hit}, 32'd0);
    check("rd_outside", bus_if.ReadData, 32'd0);
    tick();

    // Single capture: PORT_IN after 2 edges, FIFO entry after 3
    wr(5'h10, 32'd1);
    pin = 8'h3C;
    idle(1);
    idle(1);
    rd_chk("port_in_sync", 5'h04, 32'h3C);
    rd_chk("status_one", 5'h0C, 32'h0000_0010);
    rd_chk("pop_3c", 5'h08, 32'h3C);
    rd_chk("status_empty", 5'h0C, 32'h0000_0001);

    // Five changes into a depth-4 FIFO: full plus overflow
    for (int i = 1; i <= 5; i++) begin
      pin = PW'(i * 8'h11);
      idle(1);
    end
    idle(3);
    rd_chk("status_ovf", 5'h0C, 32'h0000_0046);
    rd_chk("pop_11", 5'h08, 32'h11);
    rd_chk("pop_22", 5'h08, 32'h22);
    rd_chk("pop_33", 5'h08, 32'h33);
    rd_chk("pop_44", 5'h08, 32'h44);
    rd_chk("status_ovf_empty", 5'h0C, 32'h0000_0005);
    wr(5'h0C, 32'h4);
    rd_chk("status_w1c", 5'h0C, 32'h0000_0001);

    // Full FIFO with simultaneous pop and push
    for (int i = 1; i <= 4; i++) begin
      pin = PW'(i);
      idle(1);
    end
    idle(3);
    rd_chk("status_full", 5'h0C, 32'h0000_0042);
    pin = 8'h05;
    idle(2);
    rd_chk("pop_push_full", 5'h08, 32'h01);
    rd_chk("status_still_full", 5'h0C, 32'h0000_0042);
    rd_chk("pop_02", 5'h08, 32'h02);
    rd_chk("pop_03", 5'h08, 32'h03);
    rd_chk("pop_04", 5'h08, 32'h04);
    rd_chk("pop_05", 5'h08, 32'h05);

    // Pop while empty, and no capture with cap_en cleared
    rd_chk("pop_empty", 5'h08, 32'd0);
    rd_chk("status_after_empty_pop", 5'h0C, 32'h0000_0001);
    wr(5'h10, 32'd0);
    pin = 8'hAA; idle(1);
    pin = 8'h55; idle(1);
    pin = 8'hAA; idle(1);
    idle(3);
    rd_chk("status_capoff", 5'h0C, 32'h0000_0001);

    // Asynchronous reset mid-operation
    wr(5'h10, 32'd1);
    wr(5'h00, 32'hFF);
    pin = 8'h10; idle(1);
    pin = 8'h20; idle(1);
    pin = 8'h30; idle(1);
    idle(3);
    rd_chk("status_three", 5'h0C, 32'h0000_0030);
    check("portout_ff", pout, 32'hFF);
    setbus(BASE | 32'h0C, 32'd0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_portout", pout, 32'd0);
    check("async_status", bus_if.ReadData, 32'h0000_0001);
    setbus(BASE | 32'h10, 32'd0, 1'b0, 1'b1);
    #1;
    check("async_ctrl", bus_if.ReadData, 32'd0);
    tick();
    reset = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 99) < 85)
        a = BASE | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      else
        a = $urandom();
      setbus(a, $urandom(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) begin
        v = PW'($urandom_range(0, 255));
        pin = v;
      end
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
      tick();
    end

    idle(2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
